// File: rtl/bias_add_pkg.sv
// Shared types and constant helpers for the layer-6 bias/requantize block.
package bias_add_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned N_CH_DEF       = 4;
    localparam int unsigned FRAME_PIX_DEF  = 64;
    localparam int unsigned COEFF_W_DEF    = 8;
    localparam int unsigned ACC_W_DEF      = 32;
    localparam int unsigned OUT_W_DEF      = COEFF_W_DEF;
    localparam int unsigned BIAS_SHIFT_DEF = 8;
    localparam int unsigned OUT_SHIFT_DEF  = 8;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed saturation bounds for a w-bit two's-complement word.
    function automatic int sat_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned w);
        return -sat_max(w) - 1;
    endfunction

endpackage

// File: rtl/bias_add_6_sat_shift.sv
// Arithmetic right shift plus signed saturation to OUT_W bits.
// With RELU_EN defined, negative results are clamped to zero.
module sat_shift
    import bias_add_pkg::*;
#(
    parameter int unsigned IN_W  = ACC_W_DEF + 1,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = OUT_SHIFT_DEF
) (
    input  logic [IN_W-1:0]  sum,
    output logic [OUT_W-1:0] res_c
);

    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(sat_min(OUT_W));

    logic signed [IN_W-1:0] shifted_c;

    always_comb begin
        shifted_c = $signed(sum) >>> SHIFT;
        if (shifted_c > SAT_HI) begin
            res_c = OUT_W'(SAT_HI);
        end else if (shifted_c < SAT_LO) begin
            res_c = OUT_W'(SAT_LO);
        end else begin
            res_c = OUT_W'(shifted_c);
        end
`ifdef RELU_EN
        if (res_c[OUT_W-1]) begin
            res_c = '0;
        end
`endif
    end

endmodule

// File: rtl/bias_add_6.sv
// Layer-6 bias add: loads one frame of biases, then adds them per channel to the
// accumulator stream and requantizes. Define RELU_EN to fuse a ReLU on the output.
module bias_add_6
    import bias_add_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned FRAME_PIX  = FRAME_PIX_DEF,
    parameter int unsigned COEFF_W    = COEFF_W_DEF,
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned OUT_W      = OUT_W_DEF,
    parameter int unsigned BIAS_SHIFT = BIAS_SHIFT_DEF,
    parameter int unsigned OUT_SHIFT  = OUT_SHIFT_DEF
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   acc_V_dout,
    input  logic               acc_V_empty_n,
    output logic               acc_V_read,
    output logic [OUT_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int unsigned CH_W  = cnt_w(N_CH);
    localparam int unsigned PIX_W = cnt_w(FRAME_PIX);
    localparam int unsigned SUM_W = ACC_W + 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIX - 1);

    state_t state;
    state_t state_next;

    logic [CH_W-1:0]    bias_cnt;
    logic [CH_W-1:0]    ch_cnt;
    logic [PIX_W-1:0]   pix_cnt;
    logic [COEFF_W-1:0] bias_mem [N_CH];
    logic               out_valid;
    logic [OUT_W-1:0]   out_data;

    logic               bias_xfer_c;
    logic               accept_c;
    logic               frame_done_c;
    logic signed [SUM_W-1:0] acc_wide_c;
    logic signed [SUM_W-1:0] bias_wide_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [OUT_W-1:0]   res_c;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshakes; everything is held off while reset is high.
    always_comb begin
        state_next   = state;
        bias_xfer_c  = 1'b0;
        accept_c     = 1'b0;
        frame_done_c = 1'b0;
        if (!ap_rst) begin
            case (state)
                LOAD: begin
                    bias_xfer_c = bias_V_empty_n;
                    if (bias_V_empty_n && (bias_cnt == CH_LAST)) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    accept_c     = acc_V_empty_n && (!out_valid || output_V_full_n);
                    frame_done_c = accept_c && (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);
                    if (frame_done_c) begin
                        state_next = LOAD;
                    end
                end
            endcase
        end
    end

    // Bias alignment and accumulate at ACC_W+1 bits so the sum cannot wrap.
    always_comb begin
        acc_wide_c  = SUM_W'($signed(acc_V_dout));
        bias_wide_c = SUM_W'($signed(bias_mem[ch_cnt])) <<< BIAS_SHIFT;
        sum_c       = acc_wide_c + bias_wide_c;
    end

    sat_shift #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_W),
        .SHIFT (OUT_SHIFT)
    ) u_sat_shift (
        .sum   (sum_c),
        .res_c (res_c)
    );

    // Bias register file, channel/pixel counters and the output register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            bias_cnt  <= '0;
            ch_cnt    <= '0;
            pix_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                bias_mem[i] <= '0;
            end
        end else begin
            if (bias_xfer_c) begin
                bias_mem[bias_cnt] <= bias_V_dout;
                bias_cnt <= (bias_cnt == CH_LAST) ? '0 : bias_cnt + 1'b1;
            end
            if (accept_c) begin
                out_data <= res_c;
                ch_cnt   <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
                if (ch_cnt == CH_LAST) begin
                    pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                end
            end
            // A same-cycle accept reloads the register, so valid stays set.
            if (accept_c) begin
                out_valid <= 1'b1;
            end else if (out_valid && output_V_full_n) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bias_V_read    = bias_xfer_c;
    assign acc_V_read     = accept_c;
    assign output_V_write = out_valid && !ap_rst;
    assign output_V_din   = ap_rst ? '0 : out_data;

endmodule
